// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter.
//   arb_state_e : controller state encoding (IDLE / BUSY / RESP)
//   REQ_IF      : requester index of the instruction-fetch stage
//   REQ_MEM     : requester index of the memory stage
//   WDOG_W      : watchdog counter width (covers TIMEOUT_CYC up to 65535)
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      RESP = 2'b10
   } arb_state_e;

   localparam logic REQ_IF  = 1'b0;
   localparam logic REQ_MEM = 1'b1;

   localparam int WDOG_W = 16;

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational round-robin pick between the two requesters.
// Ports:
//   Req_0, Req_1 : in  request lines (IF stage, MEM stage)
//   Last         : in  index of the requester granted most recently
//   grant_valid  : out at least one request present
//   grant_idx    : out index of the requester to grant
module arb_rr_pick
   import mem_arb_pkg::*;
(
   input  logic Req_0,
   input  logic Req_1,
   input  logic Last,
   output logic grant_valid,
   output logic grant_idx
);

   always_comb begin
      grant_valid = Req_0 | Req_1;
      if (Req_0 && Req_1) begin
         // on a tie, the requester that was not served last wins
         grant_idx = (Last == REQ_MEM) ? REQ_IF : REQ_MEM;
      end else if (Req_1) begin
         grant_idx = REQ_MEM;
      end else begin
         grant_idx = REQ_IF;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single memory port (IF stage vs MEM stage).
// One transaction at a time: grant, wait for Mem_ack, one-cycle response.
// Optional watchdog enabled by defining MEM_ARB_TIMEOUT_EN; without it the
// arbiter waits for Mem_ack indefinitely and Err_0/Err_1 stay low.
// Ports:
//   clk, rst_n            : clock (rising edge), async active-low reset
//   Req_0/Addr_0          : IF-stage read request
//   Req_1/Addr_1/We_1/Wdata_1 : MEM-stage read/write request
//   Mem_req/Mem_addr/Mem_we/Mem_wdata : memory command, valid in BUSY
//   Mem_ack/Mem_rdata     : memory completion and read data
//   Select                : registered owner, drives the shared port muxes
//   Done_0/Done_1         : one-cycle completion pulses
//   Rdata, Err_0/Err_1    : response data and timeout flag, valid with Done
//
// state | meaning
// IDLE  | no transaction; sample requests and grant one
// BUSY  | command on the memory port, waiting for Mem_ack (or timeout)
// RESP  | Done pulse to the owner with Rdata/Err; no new grant this cycle
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned TIMEOUT_CYC = 255
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              Req_0,
   input  logic              Req_1,
   input  logic [ADDR_W-1:0] Addr_0,
   input  logic [ADDR_W-1:0] Addr_1,
   input  logic              We_1,
   input  logic [DATA_W-1:0] Wdata_1,
   output logic              Mem_req,
   output logic [ADDR_W-1:0] Mem_addr,
   output logic              Mem_we,
   output logic [DATA_W-1:0] Mem_wdata,
   input  logic              Mem_ack,
   input  logic [DATA_W-1:0] Mem_rdata,
   output logic              Select,
   output logic              Done_0,
   output logic              Done_1,
   output logic [DATA_W-1:0] Rdata,
   output logic              Err_0,
   output logic              Err_1
);

   arb_state_e        state;
   arb_state_e        state_nxt;
   logic              select_q;
   logic              last_q;
   logic              err_q;
   logic [DATA_W-1:0] rdata_q;
   logic              grant_valid;
   logic              grant_idx;
   logic              timeout;
   logic              start_txn;

   arb_rr_pick u_rr_pick (
      .Req_0       (Req_0),
      .Req_1       (Req_1),
      .Last        (last_q),
      .grant_valid (grant_valid),
      .grant_idx   (grant_idx)
   );

   assign start_txn = (state == IDLE) && grant_valid;

`ifdef MEM_ARB_TIMEOUT_EN
   logic [WDOG_W-1:0] wdog_cnt;

   // Loaded with the limit on grant and counted down through BUSY; the
   // terminal count is reached after TIMEOUT_CYC further BUSY cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wdog_cnt <= '0;
      end else if (start_txn) begin
         wdog_cnt <= WDOG_W'(TIMEOUT_CYC);
      end else if ((state == BUSY) && (wdog_cnt != '0)) begin
         wdog_cnt <= wdog_cnt - WDOG_W'(1);
      end
   end

   assign timeout = (state == BUSY) && (wdog_cnt == '0);
`else
   // No watchdog in this build; the limit parameter is kept only so both
   // builds share one interface.
   logic [WDOG_W-1:0] tmo_unused;
   assign tmo_unused = WDOG_W'(TIMEOUT_CYC);
   assign timeout    = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (grant_valid) state_nxt = BUSY;
         BUSY:    if (Mem_ack || timeout) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         select_q <= REQ_IF;
         last_q   <= REQ_IF;
         err_q    <= 1'b0;
         rdata_q  <= '0;
      end else begin
         if (start_txn) begin
            select_q <= grant_idx;
            last_q   <= grant_idx;
         end
         if (state == BUSY) begin
            // an ack arriving together with the timeout wins
            if (Mem_ack) begin
               rdata_q <= Mem_rdata;
               err_q   <= 1'b0;
            end else if (timeout) begin
               rdata_q <= '0;
               err_q   <= 1'b1;
            end
         end
      end
   end

   always_comb begin
      Mem_req   = (state == BUSY);
      Select    = select_q;
      Mem_addr  = (select_q == REQ_MEM) ? Addr_1 : Addr_0;
      Mem_we    = (select_q == REQ_MEM) && We_1;
      Mem_wdata = (select_q == REQ_MEM) ? Wdata_1 : '0;
      Done_0    = (state == RESP) && (select_q == REQ_IF);
      Done_1    = (state == RESP) && (select_q == REQ_MEM);
      Err_0     = Done_0 && err_q;
      Err_1     = Done_1 && err_q;
      Rdata     = rdata_q;
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

   localparam int TMO = 4;
`ifdef MEM_ARB_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        Req_0 = 1'b0, Req_1 = 1'b0;
   logic [31:0] Addr_0 = '0, Addr_1 = '0;
   logic        We_1 = 1'b0;
   logic [31:0] Wdata_1 = '0;
   logic        Mem_req;
   logic [31:0] Mem_addr;
   logic        Mem_we;
   logic [31:0] Mem_wdata;
   logic        Mem_ack = 1'b0;
   logic [31:0] Mem_rdata = '0;
   logic        Select;
   logic        Done_0, Done_1;
   logic [31:0] Rdata;
   logic        Err_0, Err_1;

   int n_checks = 0;
   int n_fail   = 0;
   bit cmp_en   = 1'b0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TMO)) dut (
      .clk(clk), .rst_n(rst_n),
      .Req_0(Req_0), .Req_1(Req_1), .Addr_0(Addr_0), .Addr_1(Addr_1),
      .We_1(We_1), .Wdata_1(Wdata_1),
      .Mem_req(Mem_req), .Mem_addr(Mem_addr), .Mem_we(Mem_we), .Mem_wdata(Mem_wdata),
      .Mem_ack(Mem_ack), .Mem_rdata(Mem_rdata),
      .Select(Select), .Done_0(Done_0), .Done_1(Done_1),
      .Rdata(Rdata), .Err_0(Err_0), .Err_1(Err_1)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Transaction-level reference: who owns the port, how long the memory
   // has been waited on, and what the response will carry.
   int          m_owner = -1;
   bit          m_resp  = 1'b0;
   int          m_wait  = 0;
   int          m_last  = 0;
   int          m_sel   = 0;
   logic [31:0] m_rdata = '0;
   bit          m_err   = 1'b0;

   function automatic int pick(input logic r0, input logic r1, input int last);
      if (r0 && r1) return 1 - last;
      return r1 ? 1 : 0;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_owner <= -1; m_resp <= 1'b0; m_wait <= 0; m_last <= 0;
         m_sel <= 0; m_rdata <= '0; m_err <= 1'b0;
      end else if (m_resp) begin
         m_resp  <= 1'b0;
         m_owner <= -1;
      end else if (m_owner >= 0) begin
         m_wait <= m_wait + 1;
         if (Mem_ack) begin
            m_rdata <= Mem_rdata; m_err <= 1'b0; m_resp <= 1'b1;
         end else if (TMO_EN && (m_wait + 1 > TMO)) begin
            m_rdata <= '0; m_err <= 1'b1; m_resp <= 1'b1;
         end
      end else if (Req_0 || Req_1) begin
         m_owner <= pick(Req_0, Req_1, m_last);
         m_last  <= pick(Req_0, Req_1, m_last);
         m_sel   <= pick(Req_0, Req_1, m_last);
         m_wait  <= 0;
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         logic exp_req, exp_d0, exp_d1;
         exp_req = (m_owner >= 0) && !m_resp;
         exp_d0  = m_resp && (m_owner == 0);
         exp_d1  = m_resp && (m_owner == 1);
         chk("cmp_mem_req", Mem_req, exp_req);
         chk("cmp_select", Select, m_sel);
         chk("cmp_done_0", Done_0, exp_d0);
         chk("cmp_done_1", Done_1, exp_d1);
         chk("cmp_err_0", Err_0, exp_d0 && m_err);
         chk("cmp_err_1", Err_1, exp_d1 && m_err);
         if (exp_req) begin
            chk("cmp_mem_addr", Mem_addr, (m_owner == 1) ? Addr_1 : Addr_0);
            chk("cmp_mem_we", Mem_we, (m_owner == 1) ? We_1 : 1'b0);
            chk("cmp_mem_wdata", Mem_wdata, (m_owner == 1) ? Wdata_1 : 32'h0);
         end
         if (exp_d0 || exp_d1) chk("cmp_rdata", Rdata, m_rdata);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic serve(input int ack_dly, input logic [31:0] rd, output int who);
      int n;
      who = -1;
      n = 0;
      while (Mem_req !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      chk("serve_req_seen", Mem_req, 1'b1);
      if (Mem_req === 1'b1) begin
         who = int'(Select);
         repeat (ack_dly) tick();
         Mem_ack = 1'b1; Mem_rdata = rd;
         tick();
         Mem_ack = 1'b0;
         chk("serve_done", (who == 1) ? Done_1 : Done_0, 1'b1);
         chk("serve_rdata", Rdata, rd);
         tick();
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached before end of test");
      n_fail++;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "time limit");
   end

   initial begin
      int who;
      int exp_order[4];
      exp_order = '{1, 0, 1, 0};

      tick();
      cmp_en = 1'b1;
      chk("rst_mem_req", Mem_req, 1'b0);
      chk("rst_select", Select, 1'b0);
      chk("rst_done", {Done_1, Done_0}, 2'b00);
      chk("rst_err", {Err_1, Err_0}, 2'b00);
      chk("rst_rdata", Rdata, 32'h0);
      tick();
      rst_n = 1'b1;
      tick();

      // single read from requester 0, ack two cycles after Mem_req
      Req_0 = 1'b1; Addr_0 = 32'h100;
      tick();
      chk("rd_mem_req_n1", Mem_req, 1'b1);
      chk("rd_select", Select, 1'b0);
      chk("rd_addr", Mem_addr, 32'h100);
      tick();
      chk("rd_still_busy", Mem_req, 1'b1);
      chk("rd_no_early_done", Done_0, 1'b0);
      tick();
      Mem_ack = 1'b1; Mem_rdata = 32'hDEADBEEF;
      tick();
      Mem_ack = 1'b0; Req_0 = 1'b0;
      chk("rd_done_0", Done_0, 1'b1);
      chk("rd_done_1", Done_1, 1'b0);
      chk("rd_rdata", Rdata, 32'hDEADBEEF);
      chk("rd_err_0", Err_0, 1'b0);
      tick();
      chk("rd_done_drop", Done_0, 1'b0);
      chk("rd_idle", Mem_req, 1'b0);

      // both requesters held: alternate starting with requester 1
      Req_0 = 1'b1; Req_1 = 1'b1; Addr_0 = 32'h10; Addr_1 = 32'h20;
      for (int k = 0; k < 4; k++) begin
         serve(0, 32'hA000_0000 + k, who);
         chk("tie_order", who, exp_order[k]);
      end
      Req_0 = 1'b0; Req_1 = 1'b0;
      tick();

      // write from requester 1, then a read from 0 with We_1 left high
      Req_1 = 1'b1; We_1 = 1'b1; Wdata_1 = 32'h12345678; Addr_1 = 32'h200;
      tick();
      chk("wr_mem_req", Mem_req, 1'b1);
      chk("wr_select", Select, 1'b1);
      chk("wr_mem_we", Mem_we, 1'b1);
      chk("wr_mem_wdata", Mem_wdata, 32'h12345678);
      Mem_ack = 1'b1; Mem_rdata = 32'h0BAD_F00D;
      tick();
      Mem_ack = 1'b0;
      chk("wr_done_1", Done_1, 1'b1);
      Req_1 = 1'b0; Req_0 = 1'b1; Addr_0 = 32'h300;
      tick();
      chk("resp_req_not_granted", Mem_req, 1'b0);
      tick();
      chk("rd0_mem_req", Mem_req, 1'b1);
      chk("rd0_mem_we", Mem_we, 1'b0);
      chk("rd0_mem_wdata", Mem_wdata, 32'h0);
      serve(1, 32'h7777_0001, who);
      Req_0 = 1'b0; We_1 = 1'b0;
      tick();

      // reset asserted between edges while requester 1 is in BUSY
      Req_1 = 1'b1;
      tick();
      chk("rb_busy", Mem_req, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rb_mem_req_drop", Mem_req, 1'b0);
      chk("rb_select_clr", Select, 1'b0);
      chk("rb_no_done", {Done_1, Done_0}, 2'b00);
      Req_0 = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("rb_first_tie", Select, 1'b1);
      chk("rb_regrant", Mem_req, 1'b1);
      serve(0, 32'h4242_4242, who);
      Req_0 = 1'b0; Req_1 = 1'b0;
      tick();

      // stray ack while idle
      Mem_ack = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("stray_mem_req", Mem_req, 1'b0);
         chk("stray_done", {Done_1, Done_0}, 2'b00);
      end
      Mem_ack = 1'b0;
      tick();

`ifdef MEM_ARB_TIMEOUT_EN
      // no ack: timeout response five cycles after Mem_req rises
      Req_0 = 1'b1; Addr_0 = 32'h400;
      tick();
      chk("to_mem_req", Mem_req, 1'b1);
      for (int k = 1; k < 5; k++) begin
         tick();
         chk("to_wait_req", Mem_req, 1'b1);
         chk("to_wait_done", Done_0, 1'b0);
      end
      tick();
      chk("to_done_0", Done_0, 1'b1);
      chk("to_err_0", Err_0, 1'b1);
      chk("to_rdata", Rdata, 32'h0);
      Req_0 = 1'b0;
      tick();
      chk("to_idle", Mem_req, 1'b0);
      chk("to_done_drop", Done_0, 1'b0);
      tick();

      // ack on the very cycle the watchdog expires counts as an ack
      Req_0 = 1'b1;
      tick();
      repeat (4) tick();
      Mem_ack = 1'b1; Mem_rdata = 32'h5555AAAA;
      tick();
      Mem_ack = 1'b0; Req_0 = 1'b0;
      chk("tie_ack_done", Done_0, 1'b1);
      chk("tie_ack_err", Err_0, 1'b0);
      chk("tie_ack_rdata", Rdata, 32'h5555AAAA);
      tick();
`else
      // no watchdog: BUSY persists until the ack
      Req_0 = 1'b1; Addr_0 = 32'h400;
      tick();
      repeat (10) tick();
      chk("nw_still_busy", Mem_req, 1'b1);
      chk("nw_no_err", Err_0, 1'b0);
      Mem_ack = 1'b1; Mem_rdata = 32'h5555AAAA;
      tick();
      Mem_ack = 1'b0; Req_0 = 1'b0;
      chk("nw_done_0", Done_0, 1'b1);
      chk("nw_rdata", Rdata, 32'h5555AAAA);
      tick();
`endif
      tick();
      cmp_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: ADDR_W, 32, address width.
REQ-002 Parameter: DATA_W, 32, data width.
REQ-003 Parameter: TIMEOUT_CYC, 255, watchdog limit in cycles; legal range 1..65535.
REQ-004 Ports: clk  in  1  sole clock, rising edge.
REQ-005 Ports: rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-006 Ports: Req_0 / Req_1  in  1  requests from the IF stage (0) and the MEM stage (1).
REQ-007 Ports: Addr_0 / Addr_1  in  ADDR_W  request addresses.
REQ-008 Ports: We_1  in  1  write enable, requester 1 only.
REQ-009 Ports: Wdata_1  in  DATA_W  write data, requester 1 only.
REQ-010 Ports: Mem_req  out  1  memory command valid.
REQ-011 Ports: Mem_addr  out  ADDR_W  memory address.
REQ-012 Ports: Mem_we  out  1  memory write enable.
REQ-013 Ports: Mem_wdata  out  DATA_W  memory write data.
REQ-014 Ports: Mem_ack  in  1  memory completion.
REQ-015 Ports: Mem_rdata  in  DATA_W  memory read data.
REQ-016 Ports: Select  out  1  registered owner; drives the shared 2:1 port selectors.
REQ-017 Ports: Done_0 / Done_1  out  1  one-cycle completion pulses.
REQ-018 Ports: Rdata  out  DATA_W  read data, valid while Done_x is high.
REQ-019 Ports: Err_0 / Err_1  out  1  timeout flags, valid while Done_x is high.

Function
REQ-020 FSM states: IDLE, BUSY, RESP.
- IDLE->BUSY on any sampled request.
- BUSY->RESP on Mem_ack, or on timeout.
- RESP->IDLE unconditionally.
REQ-021 In IDLE with a single request, the arbiter SHALL grant that requester.
REQ-022 In IDLE with both requests, the arbiter SHALL grant the requester not served last (round-robin flag Last).
- Last updates on entry to BUSY.
- After reset, Last=0, so requester 1 wins the first tie.
REQ-023 Select SHALL be registered on IDLE->BUSY and held constant through BUSY and RESP.
REQ-024 Mem_addr, Mem_we and Mem_wdata SHALL be taken from the selected requester; Mem_we and Mem_wdata SHALL be 0 when Select=0.
REQ-025 Mem_req SHALL be 1 exactly while in BUSY.
- Request sampled at edge N gives Mem_req=1 in cycle N+1.
REQ-026 Mem_ack sampled at edge M in BUSY SHALL register Mem_rdata into Rdata and pulse Done_Select in cycle M+1 (state RESP) for exactly one cycle.
REQ-027 Mem_ack SHALL be ignored outside BUSY.
REQ-028 Requesters hold Req/Addr/Wdata until their Done. Deassertion of Req mid-transaction SHALL NOT abort the transaction; Done still pulses.
REQ-029 A request present in RESP SHALL NOT be granted until the following IDLE cycle.
- Minimum transaction length is 3 cycles.
- Done_0 and Done_1 SHALL never be high together.

Reset
REQ-030 rst_n low SHALL immediately force the following, without waiting for a clock edge:
- state=IDLE, Select=0, Last=0, Mem_req=0;
- Done_0, Done_1, Err_0 and Err_1 = 0; Rdata=0; watchdog counter=0.
REQ-031 Reset mid-transaction SHALL drop Mem_req immediately and SHALL produce no Done for the aborted transfer.

Configuration
REQ-032 Macro MEM_ARB_TIMEOUT_EN.
- Defined: a counter runs in BUSY and clears on BUSY entry. Reaching TIMEOUT_CYC cycles without Mem_ack SHALL force RESP with Err_Select=1, Rdata=0 and Done_Select=1. Mem_ack and timeout in the same cycle SHALL count as an ack.
- Undefined: no counter is present, Err_0 and Err_1 are tied 0, and BUSY waits indefinitely.

Structure
REQ-033 Package mem_arb_pkg SHALL hold the state encoding (IDLE=2'b00, BUSY=2'b01, RESP=2'b10) and the constants REQ_IF=0 and REQ_MEM=1.
REQ-034 The round-robin tie-break SHALL be the combinational sub-module arb_rr_pick.
- Inputs: Req_0, Req_1, Last.
- Outputs: grant_valid, grant_idx.

Verification
REQ-035 Single read: Req_0, Addr_0=0x100; Mem_ack 2 cycles after Mem_req, Mem_rdata=0xDEADBEEF.
- Expect Mem_req one cycle after the request and Select=0.
- Expect Done_0 for one cycle with Rdata=0xDEADBEEF.
REQ-036 Tie after reset: Req_0 and Req_1 both held.
- Expect grants in the order 1, 0, 1, 0.
- Expect no Done overlap and Select constant within each transaction.
REQ-037 Write: Req_1, We_1=1, Wdata_1=0x12345678.
- Expect Mem_we=1 and Mem_wdata=0x12345678 while Mem_req=1.
- Expect Done_1, and Mem_we=0 on the following Req_0 grant.
REQ-038 Reset during BUSY: assert rst_n=0 between clock edges.
- Expect Mem_req=0 within that cycle.
- After release, expect no Done, and the first tie grants requester 1.
REQ-039 With MEM_ARB_TIMEOUT_EN and TIMEOUT_CYC=4: Req_0, Mem_ack never asserted.
- Expect Done_0=1, Err_0=1 and Rdata=0 five cycles after Mem_req rises.
- Expect return to IDLE.
REQ-040 Stray Mem_ack in IDLE: expect no state change and no Done.
